elastic_pipe_reg: RTL and testbench

Parametrised, elastic replacement for the hard-coded ID/EX stage register: a one-beat pipeline register with valid/ready handshake, optional skid entry, flush with control-bundle bubbling, and saturating stall/bubble counters. It sits between any two pipeline stages (first instance: decode→execute). Downstream backpressure is absorbed without a combinational ready path when the skid entry is enabled. A flushed or empty slot always presents an all-zero control bundle, so no write-enable can leak downstream.

---
 rtl/pipe_pkg.sv | 18 +
 rtl/pipe_sat_counter.sv | 35 +++
 rtl/elastic_pipe_reg.sv | 162 ++++++++++++++++
 tb/tb_elastic_pipe_reg.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared types and default widths for elastic pipeline stage registers.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pipe_pkg;

  // Occupancy of the elastic register: nothing held, main only, main + skid.
  typedef enum logic [1:0] {
    PS_EMPTY = 2'd0,
    PS_FULL  = 2'd1,
    PS_SKID  = 2'd2
  } pipe_state_e;

  // Widths for the decode->execute instance.
  localparam int unsigned ID_EX_DATA_W = 128;
  localparam int unsigned ID_EX_CTRL_W = 30;
  localparam int unsigned ID_EX_CNT_W  = 16;

endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating event counter: +1 per cycle with inc_i, sticks at all-ones.
// Latency: count visible the cycle after the qualifying cycle.
// Backpressure: none; cleared only by synchronous reset.
module pipe_sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_n,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: increment unless already saturated.
  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1'b1);
    end
  end

  // Count register with synchronous active-low clear.
  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/elastic_pipe_reg.sv
// Elastic one-beat pipeline register with optional skid entry, flush and perf counters.
// Latency: 1 cycle, no input-to-output bypass; 1 beat/cycle while out_ready_i=1.
// Backpressure: SKID_EN=1 gives registered in_ready_o (skid absorbs one beat); SKID_EN=0 combinational ready.
module elastic_pipe_reg
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W  = ID_EX_DATA_W,
  parameter int unsigned CTRL_W  = ID_EX_CTRL_W,
  parameter bit          SKID_EN = 1'b1,
  parameter int unsigned CNT_W   = ID_EX_CNT_W
) (
  input  logic              clk_i,
  input  logic              rst_n,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  input  logic [CTRL_W-1:0] in_ctrl_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic [CTRL_W-1:0] out_ctrl_o,
  output logic [CNT_W-1:0]  stall_cnt_o,
  output logic [CNT_W-1:0]  bubble_cnt_o
);

  // Main (output) entry, shared by both buffering variants.
  logic              main_vld_q;
  logic              main_vld_d;
  logic              main_load;
  logic [DATA_W-1:0] main_data_q;
  logic [DATA_W-1:0] main_data_d;
  logic [CTRL_W-1:0] main_ctrl_q;
  logic [CTRL_W-1:0] main_ctrl_d;

  logic in_ready;
  logic accept;
  logic drain;

  assign accept = in_valid_i & in_ready;
  assign drain  = main_vld_q & out_ready_i;

  if (SKID_EN) begin : g_skid
    pipe_state_e       state_q;
    pipe_state_e       state_d;
    logic              skid_load;
    logic [DATA_W-1:0] skid_data_q;
    logic [CTRL_W-1:0] skid_ctrl_q;

    // Occupancy FSM: decides where an accepted beat lands and when skid refills main.
    always_comb begin
      state_d     = state_q;
      skid_load   = 1'b0;
      main_load   = 1'b0;
      main_data_d = in_data_i;
      main_ctrl_d = in_ctrl_i;
      if (flush_i) begin
        state_d = PS_EMPTY;
      end else begin
        case (state_q)
          PS_EMPTY: begin
            if (accept) begin
              state_d   = PS_FULL;
              main_load = 1'b1;
            end
          end
          PS_FULL: begin
            if (accept && !drain) begin
              state_d   = PS_SKID;
              skid_load = 1'b1;
            end else if (accept && drain) begin
              main_load = 1'b1;
            end else if (drain) begin
              state_d = PS_EMPTY;
            end
          end
          PS_SKID: begin
            if (drain) begin
              state_d     = PS_FULL;
              main_load   = 1'b1;
              main_data_d = skid_data_q;
              main_ctrl_d = skid_ctrl_q;
            end
          end
          default: state_d = PS_EMPTY;
        endcase
      end
    end

    assign main_vld_d = (state_d != PS_EMPTY);
    // Ready depends only on registered state, so no ready path crosses the stage.
    assign in_ready   = (state_q != PS_SKID);

    // State and skid entry registers; skid contents survive flush like main data.
    always_ff @(posedge clk_i) begin
      if (!rst_n) begin
        state_q     <= PS_EMPTY;
        skid_data_q <= '0;
        skid_ctrl_q <= '0;
      end else begin
        state_q <= state_d;
        if (skid_load) begin
          skid_data_q <= in_data_i;
          skid_ctrl_q <= in_ctrl_i;
        end
      end
    end
  end else begin : g_noskid
    // Single entry: load on accept, empty on drain without refill, kill on flush.
    always_comb begin
      main_data_d = in_data_i;
      main_ctrl_d = in_ctrl_i;
      main_load   = accept & ~flush_i;
      main_vld_d  = main_vld_q;
      if (flush_i) begin
        main_vld_d = 1'b0;
      end else if (accept) begin
        main_vld_d = 1'b1;
      end else if (drain) begin
        main_vld_d = 1'b0;
      end
    end

    assign in_ready = ~main_vld_q | out_ready_i;
  end

  // Main entry register; payload is only rewritten on a load so flush keeps it.
  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      main_vld_q  <= 1'b0;
      main_data_q <= '0;
      main_ctrl_q <= '0;
    end else begin
      main_vld_q <= main_vld_d;
      if (main_load) begin
        main_data_q <= main_data_d;
        main_ctrl_q <= main_ctrl_d;
      end
    end
  end

  assign in_ready_o  = in_ready;
  assign out_valid_o = main_vld_q;
  assign out_data_o  = main_data_q;
  // An empty or flushed slot must never leak a write-enable downstream.
  assign out_ctrl_o  = main_vld_q ? main_ctrl_q : '0;

  pipe_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk_i (clk_i),
    .rst_n (rst_n),
    .inc_i (main_vld_q & ~out_ready_i),
    .cnt_o (stall_cnt_o)
  );

  pipe_sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
    .clk_i (clk_i),
    .rst_n (rst_n),
    .inc_i (out_ready_i & ~main_vld_q),
    .cnt_o (bubble_cnt_o)
  );

endmodule

// File: tb/tb_elastic_pipe_reg.sv
// Directed bench for elastic_pipe_reg: skid instance (A) and no-skid instance (B).
// Latency: inputs driven #1 after posedge, outputs sampled #1 after posedge.
// Backpressure: out_ready patterns exercise skid fill/drain and combinational ready.
module tb_elastic_pipe_reg;

  localparam int unsigned DW = 16;
  localparam int unsigned CW = 8;
  localparam int unsigned NW = 4;

  logic clk_i = 1'b0;
  logic rst_n = 1'b0;
  logic flush_i = 1'b0;

  logic          in_valid_a = 1'b0, in_ready_a, out_valid_a, out_ready_a = 1'b0;
  logic [DW-1:0] in_data_a = '0, out_data_a;
  logic [CW-1:0] in_ctrl_a, out_ctrl_a;
  logic [NW-1:0] stall_a, bubble_a;

  logic          in_valid_b = 1'b0, in_ready_b, out_valid_b, out_ready_b = 1'b0;
  logic [DW-1:0] in_data_b = '0, out_data_b;
  logic [CW-1:0] in_ctrl_b, out_ctrl_b;
  logic [NW-1:0] stall_b, bubble_b;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk_i = ~clk_i;

  // Control bundle derived from payload so it is always nonzero for a real beat.
  assign in_ctrl_a = {1'b1, in_data_a[6:0]};
  assign in_ctrl_b = {1'b1, in_data_b[6:0]};

  elastic_pipe_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID_EN(1'b1), .CNT_W(NW)) u_dut_a (
    .clk_i(clk_i), .rst_n(rst_n), .flush_i(flush_i),
    .in_valid_i(in_valid_a), .in_ready_o(in_ready_a), .in_data_i(in_data_a), .in_ctrl_i(in_ctrl_a),
    .out_valid_o(out_valid_a), .out_ready_i(out_ready_a), .out_data_o(out_data_a), .out_ctrl_o(out_ctrl_a),
    .stall_cnt_o(stall_a), .bubble_cnt_o(bubble_a)
  );

  elastic_pipe_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID_EN(1'b0), .CNT_W(NW)) u_dut_b (
    .clk_i(clk_i), .rst_n(rst_n), .flush_i(flush_i),
    .in_valid_i(in_valid_b), .in_ready_o(in_ready_b), .in_data_i(in_data_b), .in_ctrl_i(in_ctrl_b),
    .out_valid_o(out_valid_b), .out_ready_i(out_ready_b), .out_data_o(out_data_b), .out_ctrl_o(out_ctrl_b),
    .stall_cnt_o(stall_b), .bubble_cnt_o(bubble_b)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    // ---------------- T1: reset values, then 4 back-to-back beats ----------------
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    chk("rst_valid",  32'(out_valid_a), 32'h0);
    chk("rst_ctrl",   32'(out_ctrl_a),  32'h0);
    chk("rst_data",   32'(out_data_a),  32'h0);
    chk("rst_stall",  32'(stall_a),     32'h0);
    chk("rst_bubble", 32'(bubble_a),    32'h0);
    chk("rst_ready",  32'(in_ready_a),  32'h1);

    in_valid_a  = 1'b1;
    out_ready_a = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      in_data_a = DW'(i);
      tick();
      chk("b2b_valid", 32'(out_valid_a), 32'h1);
      chk("b2b_data",  32'(out_data_a),  32'(i));
      chk("b2b_ctrl",  32'(out_ctrl_a),  32'h80 + 32'(i));
    end
    in_valid_a = 1'b0;
    tick();
    chk("b2b_empty_valid", 32'(out_valid_a), 32'h0);
    chk("b2b_empty_ctrl",  32'(out_ctrl_a),  32'h0);
    // Only the cycle before the first beat landed was a bubble.
    chk("b2b_bubble",      32'(bubble_a),    32'h1);

    // ---------------- T2: skid fill with 0xA,0xB,0xC and 3 stall cycles ----------------
    rst_n = 1'b0;
    out_ready_a = 1'b0;
    tick();
    rst_n = 1'b1;
    in_valid_a = 1'b1; in_data_a = 16'hA; out_ready_a = 1'b1;
    tick();
    chk("skid_a_out", 32'(out_data_a), 32'hA);
    in_data_a = 16'hB; out_ready_a = 1'b0;
    tick();
    chk("skid_ready_drop", 32'(in_ready_a), 32'h0);
    chk("skid_hold_a",     32'(out_data_a), 32'hA);
    in_data_a = 16'hC;
    tick();
    chk("skid_hold_ready", 32'(in_ready_a), 32'h0);
    tick();
    chk("skid_hold_a2",    32'(out_data_a), 32'hA);
    out_ready_a = 1'b1;
    tick();
    chk("skid_b_out",      32'(out_data_a), 32'hB);
    chk("skid_ready_rise", 32'(in_ready_a), 32'h1);
    chk("skid_stall3",     32'(stall_a),    32'h3);
    tick();
    chk("skid_c_out",      32'(out_data_a),  32'hC);
    chk("skid_c_valid",    32'(out_valid_a), 32'h1);
    in_valid_a = 1'b0;
    tick();
    chk("skid_drained",    32'(out_valid_a), 32'h0);
    chk("skid_stall_end",  32'(stall_a),     32'h3);

    // ---------------- T3: flush in SKID state with 0xD offered ----------------
    out_ready_a = 1'b0; in_valid_a = 1'b1; in_data_a = 16'h5;
    tick();
    in_data_a = 16'h6;
    tick();
    chk("fl_skid_state", 32'(in_ready_a), 32'h0);
    flush_i = 1'b1; in_data_a = 16'hD;
    tick();
    flush_i = 1'b0; in_valid_a = 1'b0; out_ready_a = 1'b1;
    chk("fl_valid",     32'(out_valid_a), 32'h0);
    chk("fl_ctrl",      32'(out_ctrl_a),  32'h0);
    chk("fl_ready",     32'(in_ready_a),  32'h1);
    chk("fl_data_kept", 32'(out_data_a),  32'h5);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("fl_no_d", 32'(out_valid_a), 32'h0);
    end
    // Flush from FULL with ready high: offered 0xE must be discarded too.
    out_ready_a = 1'b0; in_valid_a = 1'b1; in_data_a = 16'h7;
    tick();
    flush_i = 1'b1; in_data_a = 16'hE;
    tick();
    flush_i = 1'b0; in_valid_a = 1'b0;
    chk("fl_full_valid", 32'(out_valid_a), 32'h0);
    chk("fl_full_data",  32'(out_data_a),  32'h7);

    // ---------------- T4: flush and reset in the same cycle ----------------
    in_valid_a = 1'b1; in_data_a = 16'h9;
    tick();
    in_valid_a = 1'b0;
    tick();
    chk("pre_rst_data", 32'(out_data_a), 32'h9);
    rst_n = 1'b0; flush_i = 1'b1; in_valid_a = 1'b1; in_data_a = 16'hF; out_ready_a = 1'b1;
    tick();
    rst_n = 1'b1; flush_i = 1'b0; in_valid_a = 1'b0;
    chk("rstfl_valid",  32'(out_valid_a), 32'h0);
    chk("rstfl_data",   32'(out_data_a),  32'h0);
    chk("rstfl_ctrl",   32'(out_ctrl_a),  32'h0);
    chk("rstfl_stall",  32'(stall_a),     32'h0);
    chk("rstfl_bubble", 32'(bubble_a),    32'h0);
    chk("rstfl_ready",  32'(in_ready_a),  32'h1);

    // ---------------- T5: bubble counter saturation (21 = 2^4+5 cycles) ----------------
    for (int i = 0; i < 14; i++) tick();
    chk("bub_14", 32'(bubble_a), 32'd14);
    for (int i = 0; i < 7; i++) tick();
    chk("bub_sat", 32'(bubble_a), 32'd15);

    // ---------------- T6: no-skid instance, 1010 ready, 32 beats ----------------
    begin
      logic m_vld;
      logic exp_rdy;
      int   next_val;
      int   exp_out;
      int   recv;
      m_vld = 1'b0;
      next_val = 1;
      exp_out = 1;
      recv = 0;
      for (int cyc = 0; cyc < 200 && recv < 32; cyc++) begin
        out_ready_b = (cyc % 2 == 0);
        in_valid_b  = 1'b1;
        in_data_b   = DW'(next_val);
        #1;
        exp_rdy = ~m_vld | out_ready_b;
        chk("ns_ready", 32'(in_ready_b),  32'(exp_rdy));
        chk("ns_valid", 32'(out_valid_b), 32'(m_vld));
        if (m_vld && out_ready_b) begin
          chk("ns_data", 32'(out_data_b), 32'(exp_out));
          exp_out++;
          recv++;
        end
        if (exp_rdy) begin
          m_vld = 1'b1;
          next_val++;
        end else if (m_vld && out_ready_b) begin
          m_vld = 1'b0;
        end
        tick();
      end
      in_valid_b = 1'b0;
      chk("ns_recv32", 32'(recv), 32'd32);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
